alu64_cc: RTL and testbench

64-bit arithmetic/logic unit with a registered condition-code file, used by the SEQ execute stage to compute valE and the Y86-64 flags. The datapath (result and overflow) is purely combinational from the operands and function code. The ZF/SF/OF condition codes are captured on the clock edge when enabled. Implementations are roughly 120–400 lines of RTL, including the explicit 64-bit adder/subtractor and flag logic.

---
 rtl/alu64_cc.sv | 85 ++++++++
 tb/tb_alu64_cc.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu64_cc.sv
// Y86-64 execute-stage ALU: combinational 64-bit add/sub/and/xor datapath
// plus the ZF/SF/OF condition-code registers loaded under set_cc.
module alu64_cc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [3:0]  Control,
    input  logic        cc_en,
    output logic [63:0] Sum,
    output logic        Overflow,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    typedef enum logic [3:0] {
        FN_ADD = 4'd0,
        FN_SUB = 4'd1,
        FN_AND = 4'd2,
        FN_XOR = 4'd3
    } alu_fn_e;

    logic        is_sub;
    logic [63:0] add_op;
    logic [63:0] add_res;
    logic [63:0] carry;
    logic        add_ovf;
    logic        sub_ovf;

    assign is_sub = (Control == FN_SUB);
    assign add_op = is_sub ? ~A : A;

    // Shared ripple adder: B + A for add, B + ~A + 1 for subq (rB - rA).
    // The carry out of bit 63 is never formed since it is not exported.
    always_comb begin
        carry    = '0;
        add_res  = '0;
        carry[0] = is_sub;
        for (int i = 0; i < 64; i++) begin
            add_res[i] = B[i] ^ add_op[i] ^ carry[i];
            if (i < 63) begin
                carry[i+1] = (B[i] & add_op[i]) | (carry[i] & (B[i] ^ add_op[i]));
            end
        end
    end

    assign add_ovf = (A[63] == B[63]) & (add_res[63] != A[63]);
    assign sub_ovf = (A[63] != B[63]) & (add_res[63] != B[63]);

    always_comb begin
        Sum      = '0;
        Overflow = 1'b0;
        case (Control)
            FN_ADD: begin
                Sum      = add_res;
                Overflow = add_ovf;
            end
            FN_SUB: begin
                Sum      = add_res;
                Overflow = sub_ovf;
            end
            FN_AND: Sum = A & B;
            FN_XOR: Sum = A ^ B;
            default: begin
                Sum      = '0;
                Overflow = 1'b0;
            end
        endcase
    end

    // Reset value zf=1, sf=0, of=0 matches the Y86 initial condition codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= 1'b1;
            sf <= 1'b0;
            of <= 1'b0;
        end else if (cc_en) begin
            zf <= (Sum == 64'd0);
            sf <= Sum[63];
            of <= Overflow;
        end
    end

endmodule

// File: tb/tb_alu64_cc.sv
// Directed self-checking bench for alu64_cc: datapath results, flag capture,
// flag hold, and asynchronous reset behaviour.
module tb_alu64_cc;

    logic        clk;
    logic        rst_n;
    logic [63:0] A;
    logic [63:0] B;
    logic [3:0]  Control;
    logic        cc_en;
    logic [63:0] Sum;
    logic        Overflow;
    logic        zf;
    logic        sf;
    logic        of;

    int errCount;
    int checkCount;

    alu64_cc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .Control  (Control),
        .cc_en    (cc_en),
        .Sum      (Sum),
        .Overflow (Overflow),
        .zf       (zf),
        .sf       (sf),
        .of       (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
        end
    endtask

    task automatic checkFlags(input string tag, input logic ezf, input logic esf,
                              input logic eof);
        checkOutput({tag, ".zf"}, 64'(zf), 64'(ezf));
        checkOutput({tag, ".sf"}, 64'(sf), 64'(esf));
        checkOutput({tag, ".of"}, 64'(of), 64'(eof));
    endtask

    // Inputs change on the falling edge, away from the capture edge.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] ctrl, input logic en);
        @(negedge clk);
        A       = a;
        B       = b;
        Control = ctrl;
        cc_en   = en;
        #1;
    endtask

    task automatic checkDatapath(input string tag, input logic [63:0] esum,
                                 input logic eovf);
        checkOutput({tag, ".sum"}, Sum, esum);
        checkOutput({tag, ".ovf"}, 64'(Overflow), 64'(eovf));
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        rst_n      = 1'b0;
        A          = '0;
        B          = '0;
        Control    = '0;
        cc_en      = 1'b0;

        clockEdge();
        clockEdge();
        checkFlags("reset", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        clockEdge();
        checkFlags("post_release", 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(64'h8000_0000_0000_0000 + 64'(i), 64'd1, 4'd0, 1'b0);
            clockEdge();
            checkFlags("hold_no_en", 1'b1, 1'b0, 1'b0);
        end

        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 1'b1);
        checkDatapath("add_ovf", 64'h8000_0000_0000_0000, 1'b1);
        clockEdge();
        checkFlags("add_ovf_cc", 1'b0, 1'b1, 1'b1);

        applyStimulus(64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 4'd0, 1'b1);
        checkDatapath("add_neg8", 64'd8, 1'b0);
        clockEdge();
        checkFlags("add_neg8_cc", 1'b0, 1'b0, 1'b0);

        applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd0, 1'b1);
        checkDatapath("add_negovf", 64'd0, 1'b1);
        clockEdge();
        checkFlags("add_negovf_cc", 1'b1, 1'b0, 1'b1);

        applyStimulus(64'd5, 64'd5, 4'd1, 1'b1);
        checkDatapath("sub_zero", 64'd0, 1'b0);
        clockEdge();
        checkFlags("sub_zero_cc", 1'b1, 1'b0, 1'b0);

        applyStimulus(64'd7, 64'd3, 4'd1, 1'b1);
        checkDatapath("sub_neg", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        clockEdge();
        checkFlags("sub_neg_cc", 1'b0, 1'b1, 1'b0);

        applyStimulus(64'd1, 64'h8000_0000_0000_0000, 4'd1, 1'b1);
        checkDatapath("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        clockEdge();
        checkFlags("sub_ovf_cc", 1'b0, 1'b0, 1'b1);

        applyStimulus(64'hF0F0, 64'h0FF0, 4'd2, 1'b0);
        checkDatapath("and", 64'h00F0, 1'b0);
        clockEdge();
        checkFlags("and_hold", 1'b0, 1'b0, 1'b1);

        applyStimulus(64'hF0F0, 64'h0FF0, 4'd3, 1'b0);
        checkDatapath("xor", 64'hFF00, 1'b0);

        applyStimulus(64'hF0F0, 64'h0FF0, 4'd7, 1'b0);
        checkDatapath("fn7", 64'd0, 1'b0);

        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd15, 1'b0);
        checkDatapath("fn15", 64'd0, 1'b0);

        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd2, 1'b1);
        checkDatapath("and_zero", 64'd0, 1'b0);
        clockEdge();
        checkFlags("and_zero_cc", 1'b1, 1'b0, 1'b0);

        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 1'b1);
        clockEdge();
        checkFlags("pre_reset", 1'b0, 1'b1, 1'b1);

        applyStimulus(64'd3, 64'd4, 4'd0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkFlags("async_reset", 1'b1, 1'b0, 1'b0);
        checkDatapath("sum_in_reset", 64'd7, 1'b0);

        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 1'b1);
        clockEdge();
        checkFlags("reset_wins", 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        clockEdge();
        checkFlags("first_capture", 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
